// File: rtl/snake_game_core.sv
// snake_game_core: LFSR random source, fruit placement/eating and collision checking for the snake game
module snake_game_core #(
    parameter int COORD_WIDTH    = 10,
    parameter int MAX_LENGTH     = 63,
    parameter int LENGTH_WIDTH   = 6,
    parameter int DISPLAY_WIDTH  = 64,
    parameter int DISPLAY_HEIGHT = 48
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [COORD_WIDTH-1:0]              snakehead_x,
    input  logic [COORD_WIDTH-1:0]              snakehead_y,
    input  logic [COORD_WIDTH*(MAX_LENGTH+1)-1:0] snakebody_x_flat,
    input  logic [COORD_WIDTH*(MAX_LENGTH+1)-1:0] snakebody_y_flat,
    input  logic [LENGTH_WIDTH-1:0]             snake_length_in,
    input  logic [2:0]                          lives_in,
    output logic [15:0]                         random_number,
    output logic [COORD_WIDTH-1:0]              fruit_x,
    output logic [COORD_WIDTH-1:0]              fruit_y,
    output logic                                food_eaten,
    output logic [1:0]                          fruit_type,
    output logic [COORD_WIDTH*(MAX_LENGTH+1)-1:0] new_snakebody_x_flat,
    output logic [COORD_WIDTH*(MAX_LENGTH+1)-1:0] new_snakebody_y_flat,
    output logic [LENGTH_WIDTH-1:0]             fruit_snake_length_out,
    output logic [2:0]                          fruit_lives_out,
    output logic [2:0]                          collision_lives_out,
    output logic [LENGTH_WIDTH-1:0]             collision_snake_length_out,
    output logic [COORD_WIDTH-1:0]              new_head_x,
    output logic [COORD_WIDTH-1:0]              new_head_y
);
    localparam int CW = COORD_WIDTH;
    localparam int LW = LENGTH_WIDTH;
    localparam logic [LW+1:0] ONE = 1;
    localparam logic [LW+1:0] TWO = 2;
    localparam logic [LW+1:0] MAXL = MAX_LENGTH;

    logic              pending;
    logic              hit, reject, self_hit, wall_hit, collide;
    logic [CW-1:0]     cand_x, cand_y, seg_x, seg_y;
    logic [LW+1:0]     len_ext, len_grow;
    logic [LW-1:0]     len_sat;
    logic [2:0]        lives_up, lives_down;

    always_comb begin
        hit      = !pending && snakehead_x == fruit_x && snakehead_y == fruit_y;
        cand_x   = CW'(32'd1 + 32'(random_number[5:0]) % (DISPLAY_WIDTH - 2));
        cand_y   = CW'(32'd1 + 32'(random_number[11:6]) % (DISPLAY_HEIGHT - 2));
        reject   = cand_x == snakehead_x && cand_y == snakehead_y;
        self_hit = 1'b0;
        seg_x    = '0;
        seg_y    = '0;
        for (int i = 0; i <= MAX_LENGTH; i++) begin
            seg_x = snakebody_x_flat[CW*i +: CW];
            seg_y = snakebody_y_flat[CW*i +: CW];
            if (LW'(i) < snake_length_in && seg_x == cand_x && seg_y == cand_y)
                reject = 1'b1;
            // segment 0 mirrors the head, so only trailing segments count as self collision
            if (i > 0 && LW'(i) < snake_length_in && seg_x == snakehead_x && seg_y == snakehead_y)
                self_hit = 1'b1;
        end
        wall_hit   = snakehead_x == '0 || snakehead_x >= CW'(DISPLAY_WIDTH - 1) ||
                     snakehead_y == '0 || snakehead_y >= CW'(DISPLAY_HEIGHT - 1);
        collide    = wall_hit || self_hit;
        len_ext    = {2'b00, snake_length_in};
        len_grow   = fruit_type == 2'd1 ? len_ext + TWO :
                     fruit_type == 2'd2 ? (len_ext > ONE ? len_ext - ONE : ONE) : len_ext + ONE;
        len_sat    = len_grow > MAXL ? LW'(MAX_LENGTH) : len_grow[LW-1:0];
        lives_up   = lives_in == 3'd7 ? 3'd7 : lives_in + 3'd1;
        lives_down = lives_in == 3'd0 ? 3'd0 : lives_in - 3'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            random_number              <= 16'hACE1;
            fruit_x                    <= CW'(20);
            fruit_y                    <= CW'(15);
            fruit_type                 <= 2'd0;
            food_eaten                 <= 1'b0;
            pending                    <= 1'b0;
            new_snakebody_x_flat       <= '0;
            new_snakebody_y_flat       <= '0;
            fruit_snake_length_out     <= LW'(3);
            fruit_lives_out            <= 3'd3;
            collision_snake_length_out <= LW'(3);
            collision_lives_out        <= 3'd3;
            new_head_x                 <= CW'(32);
            new_head_y                 <= CW'(24);
        end else begin
            random_number <= {random_number[14:0],
                              random_number[15] ^ random_number[13] ^ random_number[12] ^ random_number[10]};
            food_eaten    <= hit;
            if (hit) begin
                pending <= 1'b1;
            end else if (pending && !reject) begin
                pending    <= 1'b0;
                fruit_x    <= cand_x;
                fruit_y    <= cand_y;
                fruit_type <= random_number[13:12];
            end
            new_snakebody_x_flat       <= hit ? {snakebody_x_flat[CW*MAX_LENGTH-1:0], snakehead_x} : snakebody_x_flat;
            new_snakebody_y_flat       <= hit ? {snakebody_y_flat[CW*MAX_LENGTH-1:0], snakehead_y} : snakebody_y_flat;
            fruit_snake_length_out     <= hit ? len_sat : snake_length_in;
            fruit_lives_out            <= hit && fruit_type == 2'd3 ? lives_up : lives_in;
            collision_lives_out        <= collide ? lives_down : lives_in;
            collision_snake_length_out <= collide ? LW'(3) : snake_length_in;
            new_head_x                 <= collide ? CW'(32) : snakehead_x;
            new_head_y                 <= collide ? CW'(24) : snakehead_y;
        end
    end
endmodule

// File: tb/tb_snake_game_core.sv
// tb_snake_game_core: directed vectors and short sequences for the snake game core
module tb_snake_game_core;
    localparam int CW = 10;
    localparam int N  = 64;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [CW-1:0]     hx, hy;
    logic [CW-1:0]     bx [0:N-1];
    logic [CW-1:0]     by [0:N-1];
    logic [CW*N-1:0]   bxf, byf;
    logic [5:0]        len;
    logic [2:0]        lives;
    logic [15:0]       random_number;
    logic [CW-1:0]     fruit_x, fruit_y, new_head_x, new_head_y;
    logic              food_eaten;
    logic [1:0]        fruit_type;
    logic [CW*N-1:0]   nbx, nby;
    logic [5:0]        fruit_len, col_len;
    logic [2:0]        fruit_lives, col_lives;

    int n_chk = 0, n_err = 0, zero_seen = 0;
    logic [15:0] m_r;
    int m_fx, m_fy, m_ft;
    bit m_pend, m_food;

    for (genvar g = 0; g < N; g++) begin : g_flat
        assign bxf[CW*g +: CW] = bx[g];
        assign byf[CW*g +: CW] = by[g];
    end

    always #5 clk = ~clk;

    snake_game_core dut (
        .clk(clk), .reset(reset),
        .snakehead_x(hx), .snakehead_y(hy),
        .snakebody_x_flat(bxf), .snakebody_y_flat(byf),
        .snake_length_in(len), .lives_in(lives),
        .random_number(random_number),
        .fruit_x(fruit_x), .fruit_y(fruit_y),
        .food_eaten(food_eaten), .fruit_type(fruit_type),
        .new_snakebody_x_flat(nbx), .new_snakebody_y_flat(nby),
        .fruit_snake_length_out(fruit_len), .fruit_lives_out(fruit_lives),
        .collision_lives_out(col_lives), .collision_snake_length_out(col_len),
        .new_head_x(new_head_x), .new_head_y(new_head_y)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference for the random source and fruit placement, advanced alongside each clock edge
    task automatic tick();
        logic [15:0] r;
        int cx, cy;
        bit ok, hit;
        r = m_r;
        if (!reset) begin
            m_r = 16'hACE1; m_fx = 20; m_fy = 15; m_ft = 0; m_pend = 0; m_food = 0;
        end else begin
            hit = !m_pend && hx == m_fx && hy == m_fy;
            if (m_pend) begin
                cx = 1 + int'(r[5:0]) % 62;
                cy = 1 + int'(r[11:6]) % 46;
                ok = !(cx == hx && cy == hy);
                for (int i = 0; i < int'(len); i++)
                    if (bx[i] == cx && by[i] == cy) ok = 0;
                if (ok) begin
                    m_fx = cx; m_fy = cy; m_ft = int'(r[13:12]); m_pend = 0;
                end
            end
            if (hit) m_pend = 1;
            m_food = hit;
            m_r = {r[14:0], r[15] ^ r[13] ^ r[12] ^ r[10]};
        end
        @(posedge clk);
        #1;
        if (random_number == 16'h0) zero_seen++;
        chk("lfsr", random_number, m_r);
        chk("fruit_x", fruit_x, m_fx);
        chk("fruit_y", fruit_y, m_fy);
        chk("fruit_type", fruit_type, m_ft);
        chk("food_eaten", food_eaten, m_food);
    endtask

    task automatic wait_reloc(input string name);
        int w = 0;
        while (m_pend && w < 100) begin
            tick();
            w++;
        end
        chk(name, m_pend, 0);
    endtask

    typedef struct {
        int hx, hy, b1x, b1y, len, lives;
        int e_lives, e_len, e_hx, e_hy;
    } col_vec_t;

    col_vec_t cv [11];
    bit seen [4];
    int ty, e;

    initial begin
        cv[0]  = '{64, 20,  1,  1,  3, 3,  2,  3, 32, 24};
        cv[1]  = '{30, 20, 30, 20,  3, 3,  2,  3, 32, 24};
        cv[2]  = '{30, 20, 30, 20,  1, 3,  3,  1, 30, 20};
        cv[3]  = '{ 0, 20,  1,  1,  5, 0,  0,  3, 32, 24};
        cv[4]  = '{10, 47,  2,  2,  2, 4,  3,  3, 32, 24};
        cv[5]  = '{62, 46,  5,  5, 10, 4,  4, 10, 62, 46};
        cv[6]  = '{ 1,  1,  1,  1,  2, 5,  4,  3, 32, 24};
        cv[7]  = '{63,  0, 63,  0,  2, 6,  5,  3, 32, 24};
        cv[8]  = '{10,  0,  1,  1,  4, 1,  0,  3, 32, 24};
        cv[9]  = '{40, 30,  1,  2, 63, 2,  2, 63, 40, 30};
        cv[10] = '{30, 20, 30, 20,  2, 3,  2,  3, 32, 24};

        for (int i = 0; i < N; i++) begin
            bx[i] = '0;
            by[i] = '0;
        end
        hx = 10; hy = 10; len = 3; lives = 3;

        // reset held for two edges, then released
        reset = 1'b0;
        tick();
        tick();
        chk("rst_lfsr", random_number, 16'hACE1);
        chk("rst_fruit", {fruit_x, fruit_y}, {10'd20, 10'd15});
        chk("rst_type", fruit_type, 0);
        chk("rst_food", food_eaten, 0);
        chk("rst_body_x", nbx == '0, 1);
        chk("rst_body_y", nby == '0, 1);
        chk("rst_flen", fruit_len, 3);
        chk("rst_flives", fruit_lives, 3);
        chk("rst_clen", col_len, 3);
        chk("rst_clives", col_lives, 3);
        chk("rst_head", {new_head_x, new_head_y}, {10'd32, 10'd24});
        reset = 1'b1;
        tick();
        chk("lfsr_step1", random_number, 16'h59C3);

        // normal fruit eaten at its reset position
        hx = 20; hy = 15;
        bx[0] = 20; by[0] = 15; bx[1] = 19; by[1] = 15; bx[2] = 18; by[2] = 15;
        tick();
        chk("eat_food", food_eaten, 1);
        chk("eat_len", fruit_len, 4);
        chk("eat_seg0", {nbx[9:0], nby[9:0]}, {10'd20, 10'd15});
        chk("eat_seg1", {nbx[19:10], nby[19:10]}, {10'd20, 10'd15});
        chk("eat_seg2", {nbx[29:20], nby[29:20]}, {10'd19, 10'd15});
        tick();
        chk("pulse_once", food_eaten, 0);
        chk("pass_len", fruit_len, 3);
        wait_reloc("reloc_wait");
        chk("fx_range", fruit_x >= 1 && fruit_x <= 62, 1);
        chk("fy_range", fruit_y >= 1 && fruit_y <= 46, 1);
        chk("fruit_off_body",
            (fruit_x == 20 && fruit_y == 15) || (fruit_x == 19 && fruit_y == 15) ||
            (fruit_x == 18 && fruit_y == 15), 0);
        tick();
        chk("no_repeat", food_eaten, 0);

        // eat fruits until bonus, poison and life types have all been seen
        len = 1; lives = 7;
        for (int k = 0; k < 300 && !(seen[1] && seen[2] && seen[3]); k++) begin
            wait_reloc("type_wait");
            ty = m_ft;
            hx = CW'(m_fx); hy = CW'(m_fy); bx[0] = hx; by[0] = hy;
            tick();
            e = ty == 1 ? 3 : ty == 2 ? 1 : 2;
            chk("type_food", food_eaten, 1);
            chk("type_len", fruit_len, e);
            chk("type_lives", fruit_lives, 7);
            seen[ty] = 1;
        end
        chk("types_seen", {29'd0, seen[1], seen[2], seen[3]}, 7);

        // collision vectors
        for (int i = 1; i < N; i++) begin
            bx[i] = '0;
            by[i] = '0;
        end
        foreach (cv[i]) begin
            hx = CW'(cv[i].hx); hy = CW'(cv[i].hy);
            bx[0] = hx; by[0] = hy; bx[1] = CW'(cv[i].b1x); by[1] = CW'(cv[i].b1y);
            len = 6'(cv[i].len); lives = 3'(cv[i].lives);
            tick();
            chk($sformatf("col%0d_lives", i), col_lives, cv[i].e_lives);
            chk($sformatf("col%0d_len", i), col_len, cv[i].e_len);
            chk($sformatf("col%0d_head", i), {new_head_x, new_head_y},
                {10'(cv[i].e_hx), 10'(cv[i].e_hy)});
        end

        // reset while a relocation is pending
        hx = 5; hy = 5; bx[0] = 5; by[0] = 5; len = 3; lives = 3;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        hx = 20; hy = 15; bx[0] = 20; by[0] = 15;
        tick();
        chk("pend_hit", food_eaten, 1);
        reset = 1'b0;
        tick();
        chk("pend_rst_fruit", {fruit_x, fruit_y}, {10'd20, 10'd15});
        chk("pend_rst_food", food_eaten, 0);
        reset = 1'b1;
        tick();
        chk("pend_cleared", food_eaten, 1);

        chk("never_zero", zero_seen, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
